// File: rtl/clk_divider_bank.sv
// Bank of NCH programmable clock dividers sharing one system clock.
// Each channel emits a square wave or a strobe; divisor updates are shadow-loaded.

module clk_divider_ch #(
  parameter int          WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 24999999
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             clk_out_o,
  output logic             pend_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, pnd_q, pnd_d;
  logic             out_q, out_d, pend_q, pend_d;
  logic             term, restart, apply;

  always_comb begin
    restart = sync_i | ~en_i;
    term    = (cnt_q == act_q);
    // Shadow divisor only lands where cnt returns to 0, so cnt never exceeds act.
    apply   = pend_q & (restart | term);
    pnd_d   = wr_i ? data_i : pnd_q;
    act_d   = apply ? pnd_d : act_q;
    pend_d  = apply ? 1'b0 : (pend_q | wr_i);
    cnt_d   = cnt_q + WIDTH'(1);
    out_d   = mode_i ? 1'b0 : out_q;
    if (restart) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      out_d = mode_i ? 1'b1 : ~out_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      act_q  <= WIDTH'(DEFAULT_DIV);
      pnd_q  <= WIDTH'(DEFAULT_DIV);
      out_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out_o = out_q;
  assign pend_o    = pend_q;
endmodule

module clk_divider_bank #(
  parameter int          NCH         = 4,
  parameter int          WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 24999999,
  parameter int          SEL_W       = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NCH-1:0]   en_i,
  input  logic [NCH-1:0]   mode_i,
  input  logic             sync_i,
  input  logic             div_wr_i,
  input  logic [SEL_W-1:0] div_sel_i,
  input  logic [WIDTH-1:0] div_data_i,
  output logic [NCH-1:0]   clk_out_o,
  output logic [NCH-1:0]   pend_o
);
  logic [NCH-1:0] wr_hit;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range selects match no channel and are dropped.
    assign wr_hit[i] = div_wr_i & (div_sel_i == SEL_W'(i));

    clk_divider_ch #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .en_i     (en_i[i]),
      .mode_i   (mode_i[i]),
      .sync_i   (sync_i),
      .wr_i     (wr_hit[i]),
      .data_i   (div_data_i),
      .clk_out_o(clk_out_o[i]),
      .pend_o   (pend_o[i])
    );
  end
endmodule
